// File: rtl/stage_mem_access.sv
// MEM pipeline stage: issues word loads/stores to data memory, stalls EX while
// the memory is not ready, raises a bus fault on misalignment or timeout, and
// holds the MEM/WB pipeline latch.
module stage_mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ex_mem_pc,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_rs2_val,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic        ex_mem_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_wb_pc,
  output logic [31:0] mem_wb_data,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_reg_write,
  output logic        mem_stall,
  output logic        mem_fault
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // wait_cnt value in the last request cycle before giving up
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rw_q, wb_rw_d;
  logic        fault_q, fault_d;

  logic access_s;
  logic misaligned_s;
  logic timeout_s;

  assign access_s     = ex_mem_mem_read | ex_mem_mem_write;
  assign misaligned_s = access_s & (ex_mem_alu_result[1:0] != 2'b00);

  // The last unanswered request cycle is not a stall: the instruction retires
  assign timeout_s = (state_q == WAIT) & ~dmem_ready & (wait_cnt_q == LAST_CNT);

  assign dmem_req   = (state_q == WAIT) ? 1'b1 : (access_s & ~misaligned_s);
  assign dmem_we    = ex_mem_mem_write;
  assign dmem_addr  = ex_mem_alu_result;
  assign dmem_wdata = ex_mem_rs2_val;
  assign mem_stall  = dmem_req & ~dmem_ready & ~timeout_s;

  assign mem_wb_pc        = wb_pc_q;
  assign mem_wb_data      = wb_data_q;
  assign mem_wb_rd        = wb_rd_q;
  assign mem_wb_reg_write = wb_rw_q;
  assign mem_fault        = fault_q;

  // Next-state, wait counter, MEM/WB latch and fault pulse computation
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wb_pc_d    = wb_pc_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_rw_d    = wb_rw_q;
    fault_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!access_s) begin
          // ALU-only instruction flows straight through
          wb_pc_d   = ex_mem_pc;
          wb_data_d = ex_mem_alu_result;
          wb_rd_d   = ex_mem_rd;
          wb_rw_d   = ex_mem_reg_write;
        end else if (misaligned_s) begin
          wb_rw_d = 1'b0;
          fault_d = 1'b1;
        end else if (dmem_ready) begin
          wb_pc_d   = ex_mem_pc;
          wb_data_d = ex_mem_mem_read ? dmem_rdata : ex_mem_alu_result;
          wb_rd_d   = ex_mem_rd;
          wb_rw_d   = ex_mem_reg_write;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = 8'd1;
          wb_rw_d    = 1'b0;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_d    = IDLE;
          wait_cnt_d = 8'd0;
          wb_pc_d    = ex_mem_pc;
          wb_data_d  = ex_mem_mem_read ? dmem_rdata : ex_mem_alu_result;
          wb_rd_d    = ex_mem_rd;
          wb_rw_d    = ex_mem_reg_write;
        end else if (timeout_s) begin
          state_d    = IDLE;
          wait_cnt_d = 8'd0;
          wb_rw_d    = 1'b0;
          fault_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          wb_rw_d    = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // State, counter and MEM/WB registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      wb_pc_q    <= 32'd0;
      wb_data_q  <= 32'd0;
      wb_rd_q    <= 5'd0;
      wb_rw_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wb_pc_q    <= wb_pc_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_rw_q    <= wb_rw_d;
      fault_q    <= fault_d;
    end
  end

endmodule

// File: tb/tb_stage_mem_access.sv
// Self-checking bench for stage_mem_access: directed scenarios followed by
// random instructions, all compared against a request-cycle-counting model.
module tb_stage_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ex_pc, ex_alu, ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mr, ex_mw, ex_rw;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] mem_wb_pc, mem_wb_data;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write, mem_stall, mem_fault;

  stage_mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ex_mem_pc(ex_pc), .ex_mem_alu_result(ex_alu), .ex_mem_rs2_val(ex_rs2),
    .ex_mem_rd(ex_rd), .ex_mem_mem_read(ex_mr), .ex_mem_mem_write(ex_mw),
    .ex_mem_reg_write(ex_rw),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_wb_pc(mem_wb_pc), .mem_wb_data(mem_wb_data), .mem_wb_rd(mem_wb_rd),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_stall(mem_stall),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model: number of request cycles already spent on the current
  // instruction, plus the expected MEM/WB latch contents.
  int          m_n;
  logic [31:0] m_pc, m_data;
  logic [4:0]  m_rd;
  logic        m_rw, m_fault;

  // Per-instruction observation counters for directed scenarios
  int n_req, n_stall, n_fault, n_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_pc = 32'd0; m_data = 32'd0; m_rd = 5'd0; m_rw = 1'b0; m_fault = 1'b0;
  endtask

  // One clock cycle with the current EX/MEM inputs; returns whether EX stalled
  task automatic step(input logic rdy, input logic [31:0] rdata, output logic stl);
    logic acc, mis, req, tmo;
    logic [1:0] lo;
    dmem_ready = rdy;
    dmem_rdata = rdata;
    #1;
    lo  = ex_alu[1:0];
    acc = ex_mr | ex_mw;
    mis = acc && (lo != 2'b00);
    req = acc && !mis;
    tmo = req && !rdy && (m_n + 1 == TO);
    stl = req && !rdy && !tmo;
    chk("dmem_req", {31'd0, dmem_req}, {31'd0, req});
    chk("dmem_we", {31'd0, dmem_we}, {31'd0, ex_mw});
    chk("dmem_addr", dmem_addr, ex_alu);
    chk("dmem_wdata", dmem_wdata, ex_rs2);
    chk("mem_stall", {31'd0, mem_stall}, {31'd0, stl});
    n_req   += int'(dmem_req);
    n_stall += int'(mem_stall);
    n_we    += int'(dmem_req & dmem_we);
    m_fault = 1'b0;
    if (!acc) begin
      m_pc = ex_pc; m_data = ex_alu; m_rd = ex_rd; m_rw = ex_rw;
    end else if (mis || tmo) begin
      m_rw = 1'b0; m_fault = 1'b1;
    end else if (rdy) begin
      m_pc = ex_pc; m_data = ex_mr ? rdata : ex_alu; m_rd = ex_rd; m_rw = ex_rw;
    end else begin
      m_rw = 1'b0;
    end
    m_n = stl ? m_n + 1 : 0;
    @(posedge clk);
    #1;
    chk("mem_wb_pc", mem_wb_pc, m_pc);
    chk("mem_wb_data", mem_wb_data, m_data);
    chk("mem_wb_rd", {27'd0, mem_wb_rd}, {27'd0, m_rd});
    chk("mem_wb_reg_write", {31'd0, mem_wb_reg_write}, {31'd0, m_rw});
    chk("mem_fault", {31'd0, mem_fault}, {31'd0, m_fault});
    n_fault += int'(mem_fault);
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic mr, input logic mw, input logic rw);
    ex_pc = pc; ex_alu = alu; ex_rs2 = rs2; ex_rd = rd; ex_mr = mr; ex_mw = mw; ex_rw = rw;
  endtask

  // Holds one instruction in EX/MEM until the stage stops stalling.
  // rdy_pat bit i gives dmem_ready in request cycle i unless rnd is set.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                           input logic [4:0] rd, input logic mr, input logic mw, input logic rw,
                           input logic [15:0] rdy_pat, input logic [31:0] rdata, input bit rnd);
    logic stl;
    int   i;
    set_ex(pc, alu, rs2, rd, mr, mw, rw);
    n_req = 0; n_stall = 0; n_fault = 0; n_we = 0;
    i = 0;
    stl = 1'b1;
    while (stl && i < 64) begin
      if (rnd) step(($urandom_range(0, 99) < 55), $urandom, stl);
      else     step(rdy_pat[i % 16], rdata, stl);
      i++;
    end
    if (stl) chk("cycle_bound", 32'd1, 32'd0);
  endtask

  initial begin
    logic stl;
    logic [1:0] kind;
    logic [31:0] addr;
    reset = 1'b1;
    set_ex(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    model_reset();
    #1;
    chk("rst_wb_data", mem_wb_data, 32'd0);
    chk("rst_wb_rw", {31'd0, mem_wb_reg_write}, 32'd0);
    chk("rst_fault", {31'd0, mem_fault}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Non-access instruction passes straight through
    run_instr(32'h40, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 16'hFFFF, 32'h0, 1'b0);
    chk("nop_data", mem_wb_data, 32'h1234);
    chk("nop_rd", {27'd0, mem_wb_rd}, 32'd5);
    chk("nop_rw", {31'd0, mem_wb_reg_write}, 32'd1);
    chk("nop_stall", n_stall, 32'd0);

    // Zero-wait load
    run_instr(32'h44, 32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 16'hFFFF, 32'hDEADBEEF, 1'b0);
    chk("ld0_req", n_req, 32'd1);
    chk("ld0_stall", n_stall, 32'd0);
    chk("ld0_data", mem_wb_data, 32'hDEADBEEF);

    // Store answered in the 4th request cycle
    run_instr(32'h48, 32'h200, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 16'b1000, 32'h0, 1'b0);
    chk("st3_we", n_we, 32'd4);
    chk("st3_stall", n_stall, 32'd3);
    chk("st3_rw", {31'd0, mem_wb_reg_write}, 32'd0);

    // Misaligned load
    run_instr(32'h4C, 32'h102, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 16'hFFFF, 32'h0, 1'b0);
    chk("mis_req", n_req, 32'd0);
    chk("mis_fault", n_fault, 32'd1);
    chk("mis_rw", {31'd0, mem_wb_reg_write}, 32'd0);

    // Timeout with memory never ready
    run_instr(32'h50, 32'h300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 16'h0000, 32'h0, 1'b0);
    chk("to_req", n_req, 32'd4);
    chk("to_stall", n_stall, 32'd3);
    chk("to_fault", n_fault, 32'd1);
    // A following ALU instruction sees an idle stage and no request
    run_instr(32'h54, 32'h77, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 32'h0, 1'b0);
    chk("to_after_req", n_req, 32'd0);
    chk("to_after_fault", n_fault, 32'd0);

    // Reset in the second WAIT cycle; EX/MEM latch clears with it
    set_ex(32'h58, 32'h400, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, stl);
    step(1'b0, 32'h0, stl);
    reset = 1'b1;
    set_ex(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("arst_req", {31'd0, dmem_req}, 32'd0);
    chk("arst_stall", {31'd0, mem_stall}, 32'd0);
    chk("arst_wb_pc", mem_wb_pc, 32'd0);
    chk("arst_wb_data", mem_wb_data, 32'd0);
    chk("arst_wb_rd", {27'd0, mem_wb_rd}, 32'd0);
    chk("arst_wb_rw", {31'd0, mem_wb_reg_write}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(32'h5C, 32'h404, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 16'b0010, 32'hCAFEF00D, 1'b0);
    chk("post_rst_data", mem_wb_data, 32'hCAFEF00D);
    chk("post_rst_rw", {31'd0, mem_wb_reg_write}, 32'd1);

    // Random instruction stream
    for (int k = 0; k < 300; k++) begin
      kind = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_instr($urandom, addr, $urandom, 5'($urandom), kind == 2'd1, kind == 2'd2,
                1'($urandom), 16'h0, 32'h0, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stage_mem_access.md
STAGE_MEM_ACCESS -- requirements
Module: stage_mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of consecutive request cycles without dmem_ready before a bus fault; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have inputs ex_mem_pc[31:0], ex_mem_alu_result[31:0], ex_mem_rs2_val[31:0] and ex_mem_rd[4:0], the EX/MEM latch contents; alu_result is the address for loads and stores.
REQ-005 SHALL have inputs ex_mem_mem_read, ex_mem_mem_write and ex_mem_reg_write, 1 bit each, the EX/MEM control bits.
REQ-006 SHALL have outputs dmem_req, dmem_we, dmem_addr[31:0] and dmem_wdata[31:0], the data-memory request, all combinational.
REQ-007 SHALL have inputs dmem_ready (1 bit) and dmem_rdata[31:0]; dmem_rdata is valid only in a cycle where dmem_req and dmem_ready are both high.
REQ-008 SHALL have registered outputs mem_wb_pc[31:0], mem_wb_data[31:0], mem_wb_rd[4:0] and mem_wb_reg_write, the MEM/WB latch.
REQ-009 SHALL have output mem_stall, 1 bit, combinational, wired to the EX-stage stall input.
REQ-010 SHALL have output mem_fault, 1 bit, a registered one-cycle pulse on a misaligned access or a bus timeout.

Function
REQ-011 SHALL define access = ex_mem_mem_read | ex_mem_mem_write.
REQ-012 SHALL define misaligned = access & (ex_mem_alu_result[1:0] != 0); only word accesses are supported.
REQ-013 SHALL implement an FSM with states IDLE and WAIT, plus a wait_cnt counter of 8 bits.
REQ-014 In IDLE, SHALL assert dmem_req when access is high and misaligned is low; in WAIT, SHALL hold dmem_req high.
REQ-015 SHALL drive dmem_addr = ex_mem_alu_result, dmem_wdata = ex_mem_rs2_val and dmem_we = ex_mem_mem_write, regardless of dmem_req.
REQ-016 SHALL drive mem_stall = dmem_req & ~dmem_ready, except in the timeout cycle (REQ-020), where mem_stall is 0.
REQ-017 When IDLE and dmem_req & dmem_ready are high, SHALL complete with zero wait states and stay in IDLE.
REQ-018 When IDLE and dmem_req is high with dmem_ready low, SHALL move to WAIT and set wait_cnt to 1.
REQ-019 When in WAIT with dmem_ready high, SHALL complete and move to IDLE.
REQ-020 When in WAIT with dmem_ready low:
- if wait_cnt == TIMEOUT-1, that cycle is the timeout cycle: move to IDLE and pulse mem_fault;
- otherwise increment wait_cnt.
REQ-021 On completion, SHALL latch mem_wb_data = dmem_rdata for a load and ex_mem_alu_result for a store; mem_wb_reg_write = ex_mem_reg_write; mem_wb_rd = ex_mem_rd; mem_wb_pc = ex_mem_pc.
REQ-022 On a non-access cycle (access = 0), SHALL pass ex_mem_* through to mem_wb_* with mem_wb_data = ex_mem_alu_result, in one cycle with no stall.
REQ-023 On every stall cycle, SHALL write mem_wb_reg_write = 0 as a bubble; other mem_wb_* fields hold their values.
REQ-024 On a misaligned access, SHALL issue no request and no stall; next cycle mem_fault = 1 and mem_wb_reg_write = 0.
REQ-025 On a timeout, SHALL set mem_wb_reg_write = 0; the instruction retires without writeback and dmem_req is low on the following cycle.
REQ-026 SHALL deassert mem_fault in every cycle not covered by REQ-024 or REQ-025.
REQ-027 SHALL depend on the EX/MEM latch holding its inputs stable while mem_stall is high, and SHALL not latch any input internally.

Reset
REQ-028 While reset is high, SHALL hold state = IDLE, wait_cnt = 0 and mem_fault = 0.
REQ-029 While reset is high, SHALL hold all mem_wb_* outputs at 0.
REQ-030 A reset asserted in WAIT SHALL take effect immediately and asynchronously: state returns to IDLE and dmem_req drops in the same cycle.

Verification
REQ-031 Non-access instruction: alu_result = 0x1234, rd = 5, reg_write = 1 -> next cycle mem_wb_data = 0x1234, mem_wb_rd = 5, mem_wb_reg_write = 1, mem_stall never asserted.
REQ-032 Zero-wait load: addr 0x100, dmem_ready tied high, rdata 0xDEADBEEF -> dmem_req for 1 cycle, mem_stall = 0, next cycle mem_wb_data = 0xDEADBEEF.
REQ-033 Three-wait store: addr 0x200, rs2 0xA5A5A5A5, ready on the 4th request cycle -> dmem_we = 1, mem_stall high 3 cycles, 3 bubbles, mem_wb_reg_write = 0 after completion.
REQ-034 Misaligned load at 0x102 -> dmem_req never asserted, mem_fault pulses 1 cycle, mem_wb_reg_write = 0.
REQ-035 Timeout with TIMEOUT = 4 and dmem_ready held low -> dmem_req high exactly 4 cycles, mem_stall high 3 cycles, one mem_fault pulse, state back in IDLE.
REQ-036 Reset asserted in the 2nd WAIT cycle -> dmem_req, mem_stall and all mem_wb_* go to 0 immediately; a subsequent load completes normally.
